maxnet_engine: RTL
==================

Name: maxnet_engine

Overview:
- Parametrised Maxnet winner-take-all engine; successor to the fixed 4-channel Maxnet datapath and controller.
- Loads N_CH unsigned activations on a start handshake and iterates x_i <= ReLU(x_i - eps * sum_{j!=i} x_j), with eps = 2^-EPS_SHIFT, at one iteration per clock.
- Reports the original value and index of the surviving channel.
- Adds beyond the 4-channel version: tie detection, an iteration cap with timeout, iteration count, and busy/done handshake.

Parameters:
N_CH, 4, number of competing channels (>=2)
DATA_W, 32, width of each unsigned activation
EPS_SHIFT, 2, inhibition weight eps = 2^-EPS_SHIFT (0 means eps = 1)
MAX_ITER, 64, iteration cap before forced termination
IDX_W, $clog2(N_CH), width of index output
CNT_W, $clog2(MAX_ITER+1), width of iteration counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
start  in  1  load request; sampled only in IDLE
x_in  in  N_CH*DATA_W  packed inputs, channel i at [i*DATA_W +: DATA_W]
busy  out  1  high in RUN and DONE
done  out  1  one-cycle pulse; results valid from this cycle on
max_value  out  DATA_W  original input of the winning channel
max_index  out  IDX_W  winning channel index
iter_count  out  CNT_W  iterations applied
tie  out  1  all remaining channels would zero simultaneously
timeout  out  1  MAX_ITER reached with more than one survivor
no_winner  out  1  all inputs were zero

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0. Working regs, original regs and counter cleared. Reset mid-RUN aborts with no done pulse.
- IDLE: on start=1 at an edge, x_in is copied into orig[] and work[], iter=0, next state RUN. start in any other state is ignored.
- Combinational per cycle in RUN:
  - S = sum of work[] at DATA_W+IDX_W+1 bits, no overflow.
  - inh_i = (S - work_i) >> EPS_SHIFT (logical).
  - nxt_i = (work_i > inh_i) ? work_i - inh_i : 0.
  - nz = count of work_i != 0.
  - low = lowest index with work_i != 0.
- RUN, at each edge, first matching rule applies:
  - nz==0: finish, no_winner=1, max_index=0, max_value=0.
  - nz==1: finish, max_index=low, max_value=orig[low].
  - all nxt_i==0: finish, tie=1, max_index=low, max_value=orig[low]. work is not updated.
  - iter==MAX_ITER: finish, timeout=1, max_index=low, max_value=orig[low].
  - Otherwise: work <= nxt, iter <= iter+1.
- Finish: result regs and iter_count are written on the same edge; state goes to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Result outputs and flags hold their values until the next accepted start, where they clear to 0 on the load edge.
- At most one of tie/timeout/no_winner is set.
- Latency: start at edge E0, k iterations applied; the finish edge is E(k+1) and done is high in the following cycle.
- A start pulse may arrive in the cycle right after done; no idle gap is required.

Test Plan:
- EPS_SHIFT=2, x={10,20,30,40} -> work after iteration 1 is {0,0,13,25}, then {0,0,7,22}, {0,0,2,21}, {0,0,0,21}. Required: max_index=3, max_value=40, iter_count=4, flags 0, done high exactly one cycle after edge E5.
- x={0,0,55,0} -> finish at E1, max_index=2, max_value=55, iter_count=0.
- x all zero -> no_winner=1, max_index=0, max_value=0, iter_count=0.
- EPS_SHIFT=0, x={8,8,0,0} -> tie=1, max_index=0, max_value=8, iter_count=0.
- EPS_SHIFT=1, MAX_ITER=16, x={8,8,0,0} -> work {4,4},{2,2},{1,1}, then stalls at 1. Required: timeout=1, max_index=0, max_value=8, iter_count=16.
- Reset asserted during RUN of the first test -> all outputs 0 immediately, no done pulse. After release, start with x={1,9,3,2} completes normally with max_index=1.
- start held high in RUN/DONE -> ignored; back-to-back start in the cycle after done is accepted.
- Parameter sweep N_CH=8, DATA_W=16 with a distinct maximum at index 6 -> max_index=6.

Source files
------------

// File: rtl/maxnet_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | maxnet_engine: parametrised Maxnet winner-take-all engine, one           |
// | lateral-inhibition iteration per clock, with tie/timeout detection.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module maxnet_engine #(
  parameter int N_CH      = 4,
  parameter int DATA_W    = 32,
  parameter int EPS_SHIFT = 2,
  parameter int MAX_ITER  = 64,
  parameter int IDX_W     = $clog2(N_CH),
  parameter int CNT_W     = $clog2(MAX_ITER + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [N_CH*DATA_W-1:0] x_in,
  output logic                   busy,
  output logic                   done,
  output logic [DATA_W-1:0]      max_value,
  output logic [IDX_W-1:0]       max_index,
  output logic [CNT_W-1:0]       iter_count,
  output logic                   tie,
  output logic                   timeout,
  output logic                   no_winner
);

  // Sum headroom: N_CH values of DATA_W bits never overflow this width.
  localparam int SUM_W = DATA_W + IDX_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_work [N_CH];
  logic [DATA_W-1:0] r_orig [N_CH];
  logic [CNT_W-1:0]  r_iter;

  logic [SUM_W-1:0]  w_sum;
  logic [DATA_W-1:0] w_nxt [N_CH];
  logic [IDX_W:0]    w_nz;
  logic [IDX_W-1:0]  w_low;
  logic              w_allz;

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_sum = w_sum + SUM_W'(r_work[i]);
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [SUM_W-1:0] w_inh;
    assign w_inh    = (w_sum - SUM_W'(r_work[g])) >> EPS_SHIFT;
    // inh < work here, so its low DATA_W bits carry the full value.
    assign w_nxt[g] = (SUM_W'(r_work[g]) > w_inh) ? r_work[g] - w_inh[DATA_W-1:0] : '0;
  end

  always_comb begin
    w_nz   = '0;
    w_low  = '0;
    w_allz = 1'b1;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (r_work[i] != '0) begin
        w_nz  = w_nz + (IDX_W + 1)'(1);
        w_low = IDX_W'(i);
      end
      if (w_nxt[i] != '0) begin
        w_allz = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_iter     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      max_value  <= '0;
      max_index  <= '0;
      iter_count <= '0;
      tie        <= 1'b0;
      timeout    <= 1'b0;
      no_winner  <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        r_work[i] <= '0;
        r_orig[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            for (int i = 0; i < N_CH; i++) begin
              r_work[i] <= x_in[i*DATA_W +: DATA_W];
              r_orig[i] <= x_in[i*DATA_W +: DATA_W];
            end
            r_iter     <= '0;
            busy       <= 1'b1;
            max_value  <= '0;
            max_index  <= '0;
            iter_count <= '0;
            tie        <= 1'b0;
            timeout    <= 1'b0;
            no_winner  <= 1'b0;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_nz == '0) begin
            no_winner  <= 1'b1;
            iter_count <= r_iter;
            done       <= 1'b1;
            r_state    <= S_DONE;
          end else if (w_nz == (IDX_W + 1)'(1) || w_allz || r_iter == CNT_W'(MAX_ITER)) begin
            // Priority order: single survivor, then tie, then timeout.
            tie        <= (w_nz != (IDX_W + 1)'(1)) && w_allz;
            timeout    <= (w_nz != (IDX_W + 1)'(1)) && !w_allz;
            max_index  <= w_low;
            max_value  <= r_orig[w_low];
            iter_count <= r_iter;
            done       <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            for (int i = 0; i < N_CH; i++) begin
              r_work[i] <= w_nxt[i];
            end
            r_iter <= r_iter + CNT_W'(1);
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
